// File: rtl/uart_cmd_tx_if.sv
// rtl/uart_cmd_tx_if.sv - command handshake between the issuing logic and uart_cmd_tx
interface uart_cmd_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] command;
  logic              str;
  logic              ready_command;
  logic              busy;
  logic              overflow;

  modport master (
    output command,
    output str,
    input  ready_command,
    input  busy,
    input  overflow
  );

  modport slave (
    input  command,
    input  str,
    output ready_command,
    output busy,
    output overflow
  );
endinterface

// File: rtl/uart_cmd_tx.sv
// rtl/uart_cmd_tx.sv - queued, parametrised UART-style command transmitter
module uart_cmd_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic         clk,
  input  logic         rst,
  uart_cmd_tx_if.slave cmd,
  output logic         tx
);
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [OCC_W-1:0] DEPTH     = OCC_W'(FIFO_DEPTH);
  localparam logic             ODD_PAR   = (PARITY == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  // command queue
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [OCC_W-1:0]  count, count_n;
  logic              str_d, push_req, push, pop, full;
  logic [DATA_W-1:0] head;
  logic              ready_q, busy_q, overflow_q;

  // serialiser
  state_t            state, state_n;
  logic [CNT_W-1:0]  baud, baud_n;
  logic [BIT_W-1:0]  bit_idx, bit_n;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;
  logic              tx_n;
  logic              baud_done;

  assign push_req = cmd.str & ~str_d;
  assign full     = (count == DEPTH);
  // a pop in the same cycle never frees room for a push that sees the queue full
  assign push     = push_req & ~full;
  assign count_n  = count + OCC_W'(push) - OCC_W'(pop);
  assign head     = mem[rd_ptr];

  assign cmd.ready_command = ready_q;
  assign cmd.busy          = busy_q;
  assign cmd.overflow      = overflow_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cmd.command;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      str_d      <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      str_d      <= cmd.str;
      count      <= count_n;
      ready_q    <= (count_n != DEPTH);
      busy_q     <= (count_n != '0) || (state_n != IDLE);
      overflow_q <= push_req & full;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      tx      <= tx_n;
      if (pop) begin
        shreg   <= head;
        par_bit <= (^head) ^ ODD_PAR;
      end
    end
  end

  assign baud_done = (baud == BAUD_LAST);

  always_comb begin
    state_n = state;
    baud_n  = baud + CNT_W'(1);
    bit_n   = bit_idx;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        baud_n = '0;
        bit_n  = '0;
        if (count != '0) begin
          pop     = 1'b1;
          state_n = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_n = '0;
          if (bit_idx == DATA_LAST) begin
            bit_n   = '0;
            state_n = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_n = bit_idx + BIT_W'(1);
          end
        end
      end
      PAR: begin
        if (baud_done) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = STOP;
        end
      end
      STOP: begin
        // bit_idx counts stop bits here so the baud counter keeps one period
        if (baud_done) begin
          baud_n = '0;
          if (bit_idx == STOP_LAST) begin
            bit_n   = '0;
            state_n = IDLE;
          end else begin
            bit_n = bit_idx + BIT_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        baud_n  = '0;
        bit_n   = '0;
      end
    endcase
  end

  // tx is registered from the next state so the line changes exactly on the edge
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg[bit_n];
      PAR:     tx_n = par_bit;
      default: tx_n = 1'b1;
    endcase
  end
endmodule
